// File: rtl/huff_pkg.sv
// Shared Huffman constants: code-length limit, symbol width, FSM state codes.
package huff_pkg;
   localparam int HUFF_MAX_LEN = 16;
   localparam int SYM_W        = 8;
   localparam int SYM_DEPTH    = 256;

   localparam logic [1:0] ST_SHIFT  = 2'd0;
   localparam logic [1:0] ST_LOOKUP = 2'd1;
   localparam logic [1:0] ST_OUT    = 2'd2;
endpackage

// File: rtl/huff_sym_ram.sv
// Canonical-order symbol store: 256x8, one write port, one read port,
// registered read (1-cycle latency, read-before-write on address collision).
module huff_sym_ram
   import huff_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [7:0]       waddr,
   input  logic [SYM_W-1:0] wdata,
   input  logic [7:0]       raddr,
   output logic [SYM_W-1:0] rdata
);

   logic [SYM_W-1:0] mem [SYM_DEPTH];

   // Write and registered read share the edge; the read sees pre-write contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/huff_decode_core.sv
// Canonical Huffman decoder: serial MSB-first bits in, one symbol per codeword out.
// Per-length counts live in registers; symbols in canonical order live in huff_sym_ram.
module huff_decode_core
   import huff_pkg::*;
#(
   parameter int MAX_LEN = HUFF_MAX_LEN,
   parameter int CNT_W   = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_we,
   input  logic [3:0]       cnt_addr,
   input  logic [CNT_W-1:0] cnt_wdata,
   input  logic             sym_we,
   input  logic [7:0]       sym_waddr,
   input  logic [SYM_W-1:0] sym_wdata,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             bit_ready,
   output logic             sym_valid,
   output logic [SYM_W-1:0] sym_out,
   input  logic             sym_ready,
   output logic [7:0]       sym_idx,
   output logic             err
);

   logic [1:0]       state;
   // Only 15 bits of the running code are kept: the 16th bit always comes
   // straight from bit_in, and a 16-bit miss clears the accumulator.
   logic [14:0]      code;
   logic [15:0]      first;
   logic [8:0]       index;
   logic [3:0]       len_m1;          // current code length minus 1
   logic [CNT_W-1:0] cnt [16];

   logic [15:0]      c;
   logic [15:0]      d;
   logic [CNT_W-1:0] cnt_cur;
   logic             hit;
   logic             last_len;
   logic [7:0]       raddr;
   logic [SYM_W-1:0] ram_rdata;

   assign c        = {code, bit_in};
   assign d        = c - first;
   assign cnt_cur  = cnt[len_m1];
   assign hit      = 32'(d) < 32'(cnt_cur);
   assign last_len = (len_m1 == 4'(MAX_LEN - 1));
   assign raddr    = index[7:0] + d[7:0];
   assign bit_ready = (state == ST_SHIFT);

   huff_sym_ram u_ram (
      .clk   (clk),
      .we    (sym_we),
      .waddr (sym_waddr),
      .wdata (sym_wdata),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   // Count table: loader writes land next cycle; reset wipes the table.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) cnt[i] <= '0;
      end else if (cnt_we) begin
         cnt[cnt_addr] <= cnt_wdata;
      end
   end

   // Decode FSM: accumulate bits, look the symbol up, hold it until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_SHIFT;
         code      <= '0;
         first     <= '0;
         index     <= '0;
         len_m1    <= '0;
         sym_valid <= 1'b0;
         sym_out   <= '0;
         sym_idx   <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_SHIFT: begin
               if (bit_valid) begin
                  if (hit || last_len) begin
                     // Both a match and an overlong code restart the accumulator.
                     code   <= '0;
                     first  <= '0;
                     index  <= '0;
                     len_m1 <= '0;
                     if (hit) state <= ST_LOOKUP;
                     else     err   <= 1'b1;
                  end else begin
                     code   <= c[14:0];
                     index  <= index + 9'(cnt_cur);
                     first  <= (first + 16'(cnt_cur)) << 1;
                     len_m1 <= len_m1 + 4'd1;
                  end
               end
            end
            ST_LOOKUP: begin
               sym_out   <= ram_rdata;
               sym_valid <= 1'b1;
               state     <= ST_OUT;
            end
            ST_OUT: begin
               if (sym_ready) begin
                  sym_valid <= 1'b0;
                  sym_idx   <= sym_idx + 8'd1;
                  state     <= ST_SHIFT;
               end
            end
            default: state <= ST_SHIFT;
         endcase
      end
   end

endmodule

// File: tb/tb_huff_decode_core.sv
// Directed bench for huff_decode_core with a queue scoreboard and a monitor.
module tb_huff_decode_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       cnt_we;
   logic [3:0] cnt_addr;
   logic [8:0] cnt_wdata;
   logic       sym_we;
   logic [7:0] sym_waddr;
   logic [7:0] sym_wdata;
   logic       bit_valid;
   logic       bit_in;
   logic       bit_ready;
   logic       sym_valid;
   logic [7:0] sym_out;
   logic       sym_ready;
   logic [7:0] sym_idx;
   logic       err;

   typedef struct { logic [7:0] sym; logic [7:0] idx; } exp_t;
   exp_t q[$];

   int         tests   = 0;
   int         fails   = 0;
   int         err_cnt = 0;
   logic [7:0] exp_idx = 8'd0;

   // Canonical codes for table cnt[len2]=3, cnt[len3]=2: 00,01,10,110,111.
   logic [2:0] cb [5];
   int         cl [5];

   huff_decode_core dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_we    (cnt_we),
      .cnt_addr  (cnt_addr),
      .cnt_wdata (cnt_wdata),
      .sym_we    (sym_we),
      .sym_waddr (sym_waddr),
      .sym_wdata (sym_wdata),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .bit_ready (bit_ready),
      .sym_valid (sym_valid),
      .sym_out   (sym_out),
      .sym_ready (sym_ready),
      .sym_idx   (sym_idx),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Monitor: sample mid-low-phase, pop on every handshake, count err pulses.
   always begin
      @(negedge clk);
      #2;
      if (err) err_cnt++;
      if (!rst && sym_valid && sym_ready) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_sym: got sym %h idx %h, required no symbol", sym_out, sym_idx);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (sym_out !== e.sym || sym_idx !== e.idx) begin
               fails++;
               $display("FAIL sym_handshake: got sym %h idx %h, required sym %h idx %h",
                        sym_out, sym_idx, e.sym, e.idx);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic write_cnt(input logic [3:0] a, input logic [8:0] v);
      cnt_we = 1'b1; cnt_addr = a; cnt_wdata = v;
      @(negedge clk);
      cnt_we = 1'b0;
   endtask

   task automatic write_sym(input logic [7:0] a, input logic [7:0] v);
      sym_we = 1'b1; sym_waddr = a; sym_wdata = v;
      @(negedge clk);
      sym_we = 1'b0;
   endtask

   task automatic load_basic();
      write_cnt(4'd1, 9'd3);
      write_cnt(4'd2, 9'd2);
      for (int i = 0; i < 5; i++) write_sym(8'(i), 8'h41 + 8'(i));
   endtask

   // Called at a negedge; returns at the negedge after the bit was taken.
   task automatic send_bit(input logic b, output int waited);
      waited = 0;
      while (!bit_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bit_ready) begin
         tests++; fails++;
         $display("FAIL bit_ready_timeout: got bit_ready 0 for %0d cycles, required 1", waited);
      end
      bit_valid = 1'b1; bit_in = b;
      @(negedge clk);
      bit_valid = 1'b0;
   endtask

   task automatic decode_sym(input int s, output int waited_first);
      int w;
      q.push_back('{sym: 8'h41 + 8'(s), idx: exp_idx});
      exp_idx++;
      for (int k = cl[s] - 1; k >= 0; k--) begin
         send_bit(cb[s][k], w);
         if (k == cl[s] - 1) waited_first = w;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || sym_valid || !bit_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got %0d symbols pending, required 0", q.size());
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!sym_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wait_sym_valid", 32'(sym_valid), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      exp_idx = 8'd0;
   endtask

   initial begin
      int         w;
      int         w1;
      int         base;
      logic [7:0] hold_sym;
      logic [7:0] hold_idx;

      cb[0] = 3'b000; cb[1] = 3'b001; cb[2] = 3'b010; cb[3] = 3'b110; cb[4] = 3'b111;
      cl[0] = 2; cl[1] = 2; cl[2] = 2; cl[3] = 3; cl[4] = 3;

      rst = 1'b1; cnt_we = 0; cnt_addr = 0; cnt_wdata = 0;
      sym_we = 0; sym_waddr = 0; sym_wdata = 0;
      bit_valid = 0; bit_in = 0; sym_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_bit_ready", 32'(bit_ready), 32'd1);
      chk("rst_sym_valid", 32'(sym_valid), 32'd0);
      chk("rst_sym_out",   32'(sym_out),   32'd0);
      chk("rst_sym_idx",   32'(sym_idx),   32'd0);
      chk("rst_err",       32'(err),       32'd0);
      rst = 1'b0;

      // Basic decode with latency: 1,1,0 -> 0x44
      load_basic();
      q.push_back('{sym: 8'h44, idx: exp_idx}); exp_idx++;
      send_bit(1'b1, w);
      send_bit(1'b1, w);
      send_bit(1'b0, w);
      chk("lat_t1_sym_valid", 32'(sym_valid), 32'd0);
      chk("lat_t1_bit_ready", 32'(bit_ready), 32'd0);
      @(negedge clk);
      chk("lat_t2_sym_valid", 32'(sym_valid), 32'd1);
      chk("lat_t2_sym_out",   32'(sym_out),   32'h44);
      chk("lat_t2_sym_idx",   32'(sym_idx),   32'd0);
      @(negedge clk);
      chk("post_hs_sym_idx",  32'(sym_idx),   32'd1);
      chk("post_hs_bit_ready", 32'(bit_ready), 32'd1);
      decode_sym(1, w);                     // 0,1 -> 0x42
      drain();

      // Back-to-back 00,10,111 with two bubble cycles per symbol
      decode_sym(0, w);
      decode_sym(2, w1);
      chk("b2b_bubble_1", 32'(w1), 32'd2);
      decode_sym(4, w1);
      chk("b2b_bubble_2", 32'(w1), 32'd2);
      drain();

      // Backpressure: symbol held for 5 cycles
      sym_ready = 1'b0;
      decode_sym(3, w);
      wait_valid();
      hold_sym = sym_out;
      hold_idx = sym_idx;
      chk("bp_sym_out", 32'(hold_sym), 32'h44);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {8'(sym_valid), 8'(bit_ready), sym_out, sym_idx},
             {8'd1, 8'd0, hold_sym, hold_idx});
      end
      sym_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_idx", 32'(sym_idx), 32'(hold_idx + 8'd1));
      chk("bp_release_valid", 32'(sym_valid), 32'd0);
      drain();

      // Overflow: empty table, sixteen 1 bits
      do_reset();
      base = err_cnt;
      for (int i = 0; i < 15; i++) send_bit(1'b1, w);
      @(negedge clk);
      chk("ovf_no_early_err", 32'(err_cnt - base), 32'd0);
      send_bit(1'b1, w);
      chk("ovf_err_pulse", 32'(err), 32'd1);
      @(negedge clk);
      chk("ovf_err_one_cycle", 32'(err), 32'd0);
      chk("ovf_err_count", 32'(err_cnt - base), 32'd1);
      chk("ovf_no_sym", 32'(sym_valid), 32'd0);
      load_basic();
      decode_sym(1, w);
      drain();
      chk("ovf_recover_idx", 32'(sym_idx), 32'd1);

      // Wrap: 257 symbols from reset
      do_reset();
      load_basic();
      for (int i = 0; i < 257; i++) begin
         decode_sym(i % 5, w);
         if (i >= 254) begin
            drain();
            chk("wrap_idx", 32'(sym_idx), 32'((i + 1) % 256));
         end
      end

      // Reset after 2 bits of a 3-bit code
      send_bit(1'b1, w);
      send_bit(1'b1, w);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_bit_ready", 32'(bit_ready), 32'd1);
      chk("rstmid_sym_valid", 32'(sym_valid), 32'd0);
      chk("rstmid_sym_out",   32'(sym_out),   32'd0);
      chk("rstmid_sym_idx",   32'(sym_idx),   32'd0);
      chk("rstmid_err",       32'(err),       32'd0);
      rst = 1'b0;
      q.delete();
      exp_idx = 8'd0;
      base = err_cnt;
      for (int i = 0; i < 16; i++) send_bit(1'b0, w);
      @(negedge clk);
      chk("rstmid_counts_cleared_err", 32'(err_cnt - base), 32'd1);

      // Reset while a symbol waits in OUT
      load_basic();
      sym_ready = 1'b0;
      send_bit(1'b0, w);
      send_bit(1'b0, w);
      wait_valid();
      rst = 1'b1;
      @(negedge clk);
      chk("rstout_sym_valid", 32'(sym_valid), 32'd0);
      chk("rstout_sym_out",   32'(sym_out),   32'd0);
      chk("rstout_bit_ready", 32'(bit_ready), 32'd1);
      rst = 1'b0;
      sym_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("rstout_dropped", 32'(sym_valid), 32'd0);
      chk("rstout_idx", 32'(sym_idx), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
